// File: rtl/ysyx_22040237_mdu_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// datapath width, MDU operation encodings and sequencer state encoding.
package ysyx_22040237_mdu_seq_pkg;

    localparam int ysyx_22040237_REG_WIDTH = 64;

    localparam logic [2:0] ysyx_22040237_MDU_OP_MUL    = 3'd0;
    localparam logic [2:0] ysyx_22040237_MDU_OP_MULH   = 3'd1;
    localparam logic [2:0] ysyx_22040237_MDU_OP_MULHSU = 3'd2;
    localparam logic [2:0] ysyx_22040237_MDU_OP_MULHU  = 3'd3;
    localparam logic [2:0] ysyx_22040237_MDU_OP_DIV    = 3'd4;
    localparam logic [2:0] ysyx_22040237_MDU_OP_DIVU   = 3'd5;
    localparam logic [2:0] ysyx_22040237_MDU_OP_REM    = 3'd6;
    localparam logic [2:0] ysyx_22040237_MDU_OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

endpackage

// File: rtl/ysyx_22040237_mdu_iter.sv
// One combinational iteration step of the MDU engine.
// Multiply: left-shift the partial product and add the multiplicand when
// the current multiplier bit is set (bits are fed MSB first).
// Divide: the low half of the partial holds the remainder; shift in the next
// dividend bit and trial-subtract the divisor. The quotient bit is returned
// separately and the upper half is passed through for the sequencer to fill.
module ysyx_22040237_mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic [2*XLEN-1:0] i_partial,
    input  logic [XLEN-1:0]   i_operand,
    input  logic              i_bit,
    input  logic              i_div,
    output logic [2*XLEN-1:0] o_partial,
    output logic              o_qbit
);

    logic [2*XLEN-1:0] w_mul_shift;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_shift;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_rem_next;

    assign w_mul_shift = {i_partial[2*XLEN-2:0], 1'b0};
    assign w_mul_next  = i_bit ? (w_mul_shift + {{XLEN{1'b0}}, i_operand}) : w_mul_shift;

    // The remainder stays below the divisor, so bit XLEN of the trial
    // difference is a clean borrow flag.
    assign w_rem_shift = {i_partial[XLEN-1:0], i_bit};
    assign w_trial     = w_rem_shift - {1'b0, i_operand};
    assign o_qbit      = i_div & ~w_trial[XLEN];
    assign w_rem_next  = o_qbit ? w_trial[XLEN-1:0] : w_rem_shift[XLEN-1:0];

    assign o_partial = i_div ? {i_partial[2*XLEN-1:XLEN], w_rem_next} : w_mul_next;

endmodule

// File: rtl/ysyx_22040237_mdu_seq.sv
// Multi-cycle multiply/divide sequencer (IDLE -> PREP -> CALC -> FIX -> DONE).
// Signed operands are reduced to magnitudes in PREP, iterated one bit per
// cycle in CALC and re-signed in FIX. Divide-by-zero and signed overflow
// results are formed in PREP and skip CALC.
// Optional macro YSYX_22040237_MDU_FAST_MUL_EN: multiplies are computed with a
// single wide product in PREP and skip CALC as well.
module ysyx_22040237_mdu_seq
    import ysyx_22040237_mdu_seq_pkg::*;
#(
    parameter int XLEN = ysyx_22040237_REG_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      mdu_op_i,
    input  logic            mdu_wop_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_idx_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic [4:0]      rd_idx_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN);

    function automatic logic op_sgn1(input logic [2:0] op);
        return (op == ysyx_22040237_MDU_OP_MULH) || (op == ysyx_22040237_MDU_OP_MULHSU) ||
               (op == ysyx_22040237_MDU_OP_DIV)  || (op == ysyx_22040237_MDU_OP_REM);
    endfunction

    function automatic logic op_sgn2(input logic [2:0] op);
        return (op == ysyx_22040237_MDU_OP_MULH) || (op == ysyx_22040237_MDU_OP_DIV) ||
               (op == ysyx_22040237_MDU_OP_REM);
    endfunction

    // Word ops only use the low 32 bits, extended by the operand's signedness.
    function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] v, input logic wop,
                                              input logic sgn);
        if (!wop) return v;
        return {{(XLEN-32){sgn & v[31]}}, v[31:0]};
    endfunction

    // Pick the product field: MUL takes the low half, MULH* the high half
    // (bits [2N-1:N]); word results are sign-extended from bit 31.
    function automatic logic [XLEN-1:0] mul_field(input logic [2:0] op, input logic wop,
                                                  input logic [2*XLEN-1:0] p);
        logic [XLEN-1:0] f;
        if (op == ysyx_22040237_MDU_OP_MUL) f = p[XLEN-1:0];
        else if (wop)                       f = {{(XLEN-32){1'b0}}, p[63:32]};
        else                                f = p[2*XLEN-1:XLEN];
        return ext_w(f, wop, 1'b1);
    endfunction

    mdu_state_e        r_state;
    logic [2:0]        r_op;
    logic              r_wop;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_s1;
    logic              r_s2;
    logic              r_pre;
    logic [XLEN-1:0]   r_res;
    logic              r_out_valid;

    logic              w_div;
    logic              w_quo_sel;
    logic              w_neg1;
    logic              w_neg2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic [XLEN-1:0]   w_most_neg;
    logic              w_div_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_special_res;
    logic              w_it_bit;
    logic [XLEN-1:0]   w_it_opnd;
    logic [2*XLEN-1:0] w_it_next;
    logic              w_qbit;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign w_div     = r_op[2];
    assign w_quo_sel = ~r_op[1];

    // PREP: magnitudes, sign flags and special-case detection on raw operands
    assign w_neg1     = op_sgn1(r_op) & r_a[XLEN-1];
    assign w_neg2     = op_sgn2(r_op) & r_b[XLEN-1];
    assign w_abs1     = w_neg1 ? (~r_a + 1'b1) : r_a;
    assign w_abs2     = w_neg2 ? (~r_b + 1'b1) : r_b;
    assign w_most_neg = r_wop ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div_zero = (r_b == '0);
    assign w_ovf      = op_sgn1(r_op) & (r_a == w_most_neg) & (&r_b);
    assign w_special_res = w_div_zero ? (w_quo_sel ? {XLEN{1'b1}} : ext_w(r_a, r_wop, 1'b1))
                                      : (w_quo_sel ? r_a : '0);

    // CALC: bits are consumed MSB first, indexed by the down-counter
    assign w_it_bit  = w_div ? r_a[r_cnt] : r_b[r_cnt];
    assign w_it_opnd = w_div ? r_b : r_a;

    ysyx_22040237_mdu_iter #(.XLEN(XLEN)) u_iter (
        .i_partial (r_acc),
        .i_operand (w_it_opnd),
        .i_bit     (w_it_bit),
        .i_div     (w_div),
        .o_partial (w_it_next),
        .o_qbit    (w_qbit)
    );

    // FIX: restore signs and select the architectural result
    assign w_prod    = (r_s1 ^ r_s2) ? (~r_acc + 1'b1) : r_acc;
    assign w_quo     = (r_s1 ^ r_s2) ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
    assign w_rem     = r_s1 ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    assign w_fix_res = w_div ? ext_w(w_quo_sel ? w_quo : w_rem, r_wop, 1'b1)
                             : mul_field(r_op, r_wop, w_prod);

`ifdef YSYX_22040237_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_p;
    // Full-width two's complement product of the sign/zero-extended operands
    assign w_fast_p = {{XLEN{op_sgn1(r_op) & r_a[XLEN-1]}}, r_a} *
                      {{XLEN{op_sgn2(r_op) & r_b[XLEN-1]}}, r_b};
`endif

    // Sequencer FSM: owns every register, flush overrides all states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_wop       <= 1'b0;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_pre       <= 1'b0;
            r_res       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush_i) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_op    <= mdu_op_i;
                        r_wop   <= mdu_wop_i;
                        r_rd    <= rd_idx_i;
                        r_a     <= ext_w(op1_i, mdu_wop_i, op_sgn1(mdu_op_i));
                        r_b     <= ext_w(op2_i, mdu_wop_i, op_sgn2(mdu_op_i));
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_s1  <= w_neg1;
                    r_s2  <= w_neg2;
                    r_a   <= w_abs1;
                    r_b   <= w_abs2;
                    r_acc <= '0;
                    r_cnt <= r_wop ? CW'(31) : CW'(XLEN-1);
                    // Short-path results are final here; FIX just forwards them
                    if (w_div && (w_div_zero || w_ovf)) begin
                        r_res   <= w_special_res;
                        r_pre   <= 1'b1;
                        r_state <= ST_FIX;
`ifdef YSYX_22040237_MDU_FAST_MUL_EN
                    end else if (!w_div) begin
                        r_res   <= mul_field(r_op, r_wop, w_fast_p);
                        r_pre   <= 1'b1;
                        r_state <= ST_FIX;
`endif
                    end else begin
                        r_pre   <= 1'b0;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_div ? {r_acc[2*XLEN-2:XLEN], w_qbit, w_it_next[XLEN-1:0]}
                                   : w_it_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    if (!r_pre) r_res <= w_fix_res;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign out_valid_o = r_out_valid;
    assign res_o       = r_res;
    assign rd_idx_o    = r_rd;

endmodule

// File: tb/tb_ysyx_22040237_mdu_seq.sv
// Self-checking bench for ysyx_22040237_mdu_seq: directed corner cases,
// backpressure, flush, mid-operation reset and randomized operations
// compared against a plain-arithmetic RISC-V M-extension reference.
module tb_ysyx_22040237_mdu_seq;

`ifdef YSYX_22040237_MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  mdu_op = '0;
    logic        mdu_wop = 1'b0;
    logic [63:0] op1 = '0;
    logic [63:0] op2 = '0;
    logic [4:0]  rd_idx = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] res;
    logic [4:0]  rd_out;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    ysyx_22040237_mdu_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mdu_op_i    (mdu_op),
        .mdu_wop_i   (mdu_wop),
        .op1_i       (op1),
        .op2_i       (op2),
        .rd_idx_i    (rd_idx),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res),
        .rd_idx_o    (rd_out),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RISC-V M semantics with ordinary arithmetic
    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic wop,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, pp;
        logic [31:0]  a32, b32, q32, r32, m32;
        logic [63:0]  q, r;
        logic         sgn;
        sgn = (op == 3'd4) || (op == 3'd6);
        if (!op[2]) begin
            if (wop) begin
                m32 = a[31:0] * b[31:0];
                return {{32{m32[31]}}, m32};
            end
            pa = (op == 3'd1 || op == 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
            pb = (op == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
            pp = pa * pb;
            return (op == 3'd0) ? pp[63:0] : pp[127:64];
        end
        if (wop) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 0;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            return op[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end
        if (b == 0) begin
            q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
            q = a; r = 0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic wop,
                                   input logic [63:0] a, input logic [63:0] b);
        logic sgn;
        sgn = (op == 3'd4) || (op == 3'd6);
        if (!op[2]) return FAST ? 2 : (wop ? 34 : 66);
        if (wop) begin
            if (b[31:0] == 0 || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))
                return 2;
            return 34;
        end
        if (b == 0 || (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF))
            return 2;
        return 66;
    endfunction

    // Issue one operation, measure latency, optionally hold off the consumer
    task automatic run_op(input logic [2:0] op, input logic wop, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int hold);
        int         lat;
        logic [4:0] rd;
        rd = 5'($urandom);
        @(negedge clk);
        check_val("ready_idle", in_ready, 1);
        in_valid = 1'b1; mdu_op = op; mdu_wop = wop; op1 = a; op2 = b; rd_idx = rd;
        @(posedge clk); #1;
        in_valid = 1'b0; op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom}; rd_idx = ~rd;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", lat, ref_lat(op, wop, a, b));
        check_val("result", res, exp);
        check_val("rd_idx", rd_out, rd);
        check_val("busy_done", busy, 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", out_valid, 1);
            check_val("hold_result", res, exp);
            check_val("hold_rd", rd_out, rd);
            check_val("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("exit_valid", out_valid, 0);
        check_val("exit_ready", in_ready, 1);
        $display("op=%0d w=%0d a=%h b=%h res=%h exp=%h lat=%0d hold=%0d",
                 op, wop, a, b, res, exp, lat, hold);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return {32'd0, $urandom};
            4:       return 64'($urandom_range(0, 20));
            5:       return 64'hFFFF_FFFF_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic        wop;
        logic [63:0] a, b;
        int          seen;

        #1;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_res", res, 0);
        check_val("rst_rd", rd_out, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", in_ready, 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        run_op(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 0);
        run_op(3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 0);
        run_op(3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 0);
        run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 0);
        run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        run_op(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 0);
        run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4, 0);
        run_op(3'd5, 1'b0, 64'd1000, 64'd10, 64'd100, 10);

        // Flush in the middle of CALC
        @(negedge clk);
        in_valid = 1'b1; mdu_op = 3'd5; mdu_wop = 1'b0; op1 = 64'd1000; op2 = 64'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (21) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_val("flush_busy", busy, 0);
        check_val("flush_valid", out_valid, 0);
        check_val("flush_ready", in_ready, 1);
        // Flush together with a request: nothing may be accepted
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_val("flush_no_accept", busy, 0);
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_val("flush_no_result", seen, 0);
        $display("flush test: stray results=%0d", seen);

        // Reset asserted mid-CALC
        run_op(3'd4, 1'b0, 64'd77, 64'd5, 64'd15, 0);
        @(negedge clk);
        in_valid = 1'b1; mdu_op = 3'd7; mdu_wop = 1'b0; op1 = 64'd999; op2 = 64'd13; rd_idx = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_res", res, 0);
        check_val("mid_rst_rd", rd_out, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_ready", in_ready, 1);
        $display("mid-operation reset: busy=%0d valid=%0d res=%h", busy, out_valid, res);
        @(negedge clk);
        rst = 1'b1;

        for (int n = 0; n < 40; n++) begin
            op  = 3'($urandom_range(0, 7));
            wop = 1'($urandom_range(0, 1));
            if (wop && !op[2]) op = 3'd0;
            a = pick_operand();
            b = pick_operand();
            run_op(op, wop, a, b, ref_res(op, wop, a, b), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
